// File: rtl/cv32e40p_fetch_request_ctrl.sv
// Instruction fetch request controller: issues OBI fetches under FIFO credit,
// handles PC redirects and discards stale responses, and buffers instructions with their PC.
module cv32e40p_fetch_request_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [31:0]   r_req_addr;
  logic          r_req_pend;
  logic          r_addr_vld;
  logic          r_br_pend;
  logic [31:0]   r_br_tgt;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];

  logic [31:0]   w_target;
  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_req;
  logic          w_gnt;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_disc_nxt;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_target   = {branch_addr_i[31:2], 2'b00};
  assign w_inflight = {1'b0, r_out} + {1'b0, r_cnt};
  assign w_credit   = w_inflight < CW1'(FIFO_DEPTH);
  // A request left ungranted must stay up; no fetch at all until a boot redirect arrives.
  assign w_req      = r_req_pend | (req_i & r_addr_vld & w_credit);
  assign w_gnt      = w_req & instr_gnt_i;
  assign w_out_nxt  = r_out + CW'(w_gnt) - CW'(instr_rvalid_i);
  assign w_drop     = branch_i | (r_disc != '0);
  assign w_push     = instr_rvalid_i & ~w_drop;
  assign w_pop      = (r_cnt != '0) & fetch_ready_i & ~branch_i;

  always_comb begin
    w_disc_nxt = r_disc;
    if (branch_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      w_disc_nxt = w_out_nxt;
    end else begin
      if (instr_rvalid_i && (r_disc != '0)) w_disc_nxt = w_disc_nxt - CW'(1);
      // Grant of a request that was held across a redirect returns stale data.
      if (w_gnt && r_br_pend) w_disc_nxt = w_disc_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_addr <= '0;
      r_req_pend <= 1'b0;
      r_addr_vld <= 1'b0;
      r_br_pend  <= 1'b0;
      r_br_tgt   <= '0;
      r_out      <= '0;
      r_disc     <= '0;
    end else begin
      r_req_pend <= w_req & ~instr_gnt_i;
      r_out      <= w_out_nxt;
      r_disc     <= w_disc_nxt;
      if (branch_i) begin
        r_addr_vld <= 1'b1;
        if (w_req && !instr_gnt_i) begin
          r_br_pend <= 1'b1;
          r_br_tgt  <= w_target;
        end else begin
          r_br_pend  <= 1'b0;
          r_req_addr <= w_target;
        end
      end else if (w_gnt) begin
        r_req_addr <= r_br_pend ? r_br_tgt : r_req_addr + 32'd4;
        r_br_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_rsp_pc <= '0;
    end else if (branch_i) begin
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_rsp_pc <= w_target;
    end else begin
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wr     <= ptr_inc(r_wr);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= instr_rdata_i;
      r_mem_pc[r_wr]   <= r_rsp_pc;
    end
  end

  assign instr_req_o   = w_req;
  assign instr_addr_o  = r_req_addr;
  assign fetch_valid_o = (r_cnt != '0);
  assign fetch_rdata_o = fetch_valid_o ? r_mem_data[r_rd] : '0;
  assign fetch_addr_o  = fetch_valid_o ? r_mem_pc[r_rd] : '0;
  assign busy_o        = w_req | (r_out != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_cnt == CW'(FIFO_DEPTH))));

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && (r_out == '0)));

endmodule

// File: tb/tb_cv32e40p_fetch_request_ctrl.sv
// Directed bench: depth-2 instance for most scenarios, depth-4 instance for deep-discard and reset.
module tb_cv32e40p_fetch_request_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        req, branch, gnt, rvalid, ready;
  logic [31:0] baddr, rdata;

  logic        a_req, a_fv, a_busy, b_req, b_fv, b_busy;
  logic [31:0] a_addr, a_fd, a_fa, b_addr, b_fd, b_fa;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40p_fetch_request_ctrl #(.FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_a), .req_i(req), .branch_i(branch), .branch_addr_i(baddr),
    .instr_req_o(a_req), .instr_gnt_i(gnt), .instr_addr_o(a_addr),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .fetch_valid_o(a_fv), .fetch_ready_i(ready), .fetch_rdata_o(a_fd),
    .fetch_addr_o(a_fa), .busy_o(a_busy)
  );

  cv32e40p_fetch_request_ctrl #(.FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_b), .req_i(req), .branch_i(branch), .branch_addr_i(baddr),
    .instr_req_o(b_req), .instr_gnt_i(gnt), .instr_addr_o(b_addr),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .fetch_valid_o(b_fv), .fetch_ready_i(ready), .fetch_rdata_o(b_fd),
    .fetch_addr_o(b_fa), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    req = 0; branch = 0; gnt = 0; rvalid = 0; ready = 0;
    baddr = '0; rdata = '0;
    #1;
    chk("rst_req", a_req, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_fv", a_fv, 0);
    chk("rst_busy", b_busy, 0);
    tick; tick;
    rst_a = 1'b1;

    // boot redirect to misaligned 0x1C000082
    branch = 1; baddr = 32'h1C00_0082; req = 1; gnt = 1;
    #1 chk("boot_noreq", a_req, 0);
    tick;
    branch = 0;
    #1 chk("boot_req", a_req, 1);
    chk("boot_addr0", a_addr, 32'h1C00_0080);
    tick;
    rvalid = 1; rdata = 32'hAAAA_0001;
    #1 chk("boot_addr1", a_addr, 32'h1C00_0084);
    tick;
    rdata = 32'hAAAA_0002; ready = 1;
    #1 chk("credit_full", a_req, 0);
    chk("fv0", a_fv, 1);
    chk("fa0", a_fa, 32'h1C00_0080);
    chk("fd0", a_fd, 32'hAAAA_0001);
    tick;
    rvalid = 0; req = 0; gnt = 0;
    #1 chk("fa1", a_fa, 32'h1C00_0084);
    chk("fd1", a_fd, 32'hAAAA_0002);
    chk("idle_busy", a_busy, 0);
    tick;
    ready = 0;
    #1 chk("empty", a_fv, 0);

    // credit limit with consumer stalled
    req = 1; gnt = 1;
    #1 chk("cr_addr0", a_addr, 32'h1C00_0088);
    tick;
    #1 chk("cr_addr1", a_addr, 32'h1C00_008C);
    tick;
    rvalid = 1; rdata = 32'h0000_0011;
    #1 chk("cr_stop0", a_req, 0);
    tick;
    rdata = 32'h0000_0022;
    #1 chk("cr_stop1", a_req, 0);
    tick;
    rvalid = 0; ready = 1;
    #1 chk("cr_stop2", a_req, 0);
    chk("cr_fa", a_fa, 32'h1C00_0088);
    tick;
    #1 chk("cr_resume", a_req, 1);
    chk("cr_fd", a_fd, 32'h0000_0022);
    req = 0; gnt = 0;
    tick;
    ready = 0;

    // redirect while 0x1008 is pending ungranted
    branch = 1; baddr = 32'h0000_1008;
    tick;
    branch = 0; req = 1;
    #1 chk("pd_addr", a_addr, 32'h0000_1008);
    tick;
    branch = 1; baddr = 32'h0000_2000; req = 0;
    #1 chk("pd_hold_req", a_req, 1);
    tick;
    branch = 0;
    #1 chk("pd_hold_addr", a_addr, 32'h0000_1008);
    chk("pd_hold_req2", a_req, 1);
    gnt = 1;
    tick;
    req = 1; rvalid = 1; rdata = 32'hDEAD_1008;
    #1 chk("pd_tgt", a_addr, 32'h0000_2000);
    tick;
    req = 0; gnt = 0; rdata = 32'h2000_2000;
    #1 chk("pd_drop", a_fv, 0);
    tick;
    rvalid = 0;
    #1 chk("pd_fv", a_fv, 1);
    chk("pd_fa", a_fa, 32'h0000_2000);
    chk("pd_fd", a_fd, 32'h2000_2000);
    ready = 1;
    tick;
    ready = 0;

    // address wrap
    branch = 1; baddr = 32'hFFFF_FFFC;
    tick;
    branch = 0; req = 1; gnt = 1;
    #1 chk("wr_addr0", a_addr, 32'hFFFF_FFFC);
    tick;
    req = 0; gnt = 0; rvalid = 1; rdata = 32'hC0DE_C0DE;
    #1 chk("wr_addr1", a_addr, 32'h0000_0000);
    tick;
    rvalid = 0;
    #1 chk("wr_fa", a_fa, 32'hFFFF_FFFC);
    ready = 1;
    tick;
    ready = 0;

    // switch to depth-4 instance: redirect with 3 in flight, one responding
    rst_a = 1'b0; rst_b = 1'b1;
    branch = 1; baddr = 32'h0000_4000;
    tick;
    branch = 0; req = 1; gnt = 1;
    #1 chk("dp_addr0", b_addr, 32'h0000_4000);
    tick;
    #1 chk("dp_addr1", b_addr, 32'h0000_4004);
    tick;
    rvalid = 1; rdata = 32'h4000_4000;
    #1 chk("dp_addr2", b_addr, 32'h0000_4008);
    tick;
    rvalid = 0;
    #1 chk("dp_req3", b_req, 1);
    tick;
    req = 0; gnt = 0; branch = 1; baddr = 32'h0000_5000; rvalid = 1; rdata = 32'hBAD0_4004;
    #1 chk("dp_fv_pre", b_fv, 1);
    chk("dp_fa_pre", b_fa, 32'h0000_4000);
    tick;
    branch = 0; rdata = 32'hBAD1_4008;
    #1 chk("dp_flush", b_fv, 0);
    chk("dp_tgt", b_addr, 32'h0000_5000);
    tick;
    rdata = 32'hBAD2_400C;
    #1 chk("dp_drop1", b_fv, 0);
    tick;
    rvalid = 0;
    #1 chk("dp_drop2", b_fv, 0);
    chk("dp_busy", b_busy, 0);
    req = 1; gnt = 1;
    tick;
    req = 0; gnt = 0; rvalid = 1; rdata = 32'h5000_5000;
    tick;
    rvalid = 0;
    #1 chk("dp_fa", b_fa, 32'h0000_5000);
    chk("dp_fd", b_fd, 32'h5000_5000);

    // reset with two outstanding and one buffered
    req = 1; gnt = 1;
    tick; tick;
    req = 0; gnt = 0;
    #1 chk("rs_busy", b_busy, 1);
    rst_b = 1'b0;
    #1 chk("rs_addr", b_addr, 0);
    chk("rs_busy0", b_busy, 0);
    chk("rs_fv", b_fv, 0);
    chk("rs_fd", b_fd, 0);
    chk("rs_fa", b_fa, 0);
    tick;
    rst_b = 1'b1; req = 1; gnt = 1;
    #1 chk("rs_noboot", b_req, 0);
    tick;
    #1 chk("rs_nostale", b_fv, 0);
    chk("rs_noreq", b_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
